// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg
// Shared definitions for the trap/MRET sequencer:
//   - sequencer state encoding
//   - machine interrupt cause codes (external 11, software 3, timer 7)
//   - machine CSR addresses and CSR port op codes
//   - trap_target(): trap vector computation from an mtvec value
package trap_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_RD_MST,
      ST_WR_MST,
      ST_WR_EPC,
      ST_WR_CAUSE,
      ST_RD_TVEC,
      ST_RD_EPC,
      ST_REDIR
   } seq_state_e;

   localparam logic [3:0] CAUSE_M_EXT   = 4'd11;
   localparam logic [3:0] CAUSE_M_SW    = 4'd3;
   localparam logic [3:0] CAUSE_M_TIMER = 4'd7;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [1:0] CSR_OP_READ  = 2'b00;
   localparam logic [1:0] CSR_OP_WRITE = 2'b01;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Only mode 01 (vectored) offsets the base, and only for interrupts.
   // Exceptions always land on the base; reserved modes 1x act as direct.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                               input logic        intr,
                                               input logic [3:0]  cause);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (mtvec[1:0] == 2'b01 && intr)
         return base + {26'd0, cause, 2'b00};
      return base;
   endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
// CSR access port bundle around the trap sequencer.
//   pipe_csr_addr_i/data_i/op_i/we_i : request from the pipeline
//   csr_addr_o/data_o/op_o/we_o      : request forwarded to the CSR unit
//   csr_rdata_i                      : combinational read data for csr_addr_o
// master: the sequencer side; slave: the pipeline / CSR unit side.
interface trap_sequencer_if;

   logic [11:0] pipe_csr_addr_i;
   logic [31:0] pipe_csr_data_i;
   logic [1:0]  pipe_csr_op_i;
   logic        pipe_csr_we_i;

   logic [11:0] csr_addr_o;
   logic [31:0] csr_data_o;
   logic [1:0]  csr_op_o;
   logic        csr_we_o;

   logic [31:0] csr_rdata_i;

   modport master (
      input  pipe_csr_addr_i, pipe_csr_data_i, pipe_csr_op_i, pipe_csr_we_i,
      input  csr_rdata_i,
      output csr_addr_o, csr_data_o, csr_op_o, csr_we_o
   );

   modport slave (
      output pipe_csr_addr_i, pipe_csr_data_i, pipe_csr_op_i, pipe_csr_we_i,
      output csr_rdata_i,
      input  csr_addr_o, csr_data_o, csr_op_o, csr_we_o
   );

endinterface

// File: rtl/trap_sequencer_prio_enc.sv
// trap_sequencer_prio_enc
// Combinational event priority encoder for the trap sequencer.
//   except_valid_i/except_cause_i : synchronous exception and its cause
//   irq_i                         : {external, software, timer}, pre-gated
//   mret_i                        : MRET in execute
//   valid/intr/cause/is_mret      : winning event description
// Priority: exception > external > software > timer > MRET.
module trap_sequencer_prio_enc
   import trap_sequencer_pkg::*;
(
   input  logic       except_valid_i,
   input  logic [3:0] except_cause_i,
   input  logic [2:0] irq_i,
   input  logic       mret_i,
   output logic       valid,
   output logic       intr,
   output logic [3:0] cause,
   output logic       is_mret
);

   always_comb begin
      valid   = 1'b1;
      intr    = 1'b0;
      cause   = 4'd0;
      is_mret = 1'b0;
      if (except_valid_i) begin
         cause = except_cause_i;
      end else if (irq_i[2]) begin
         intr  = 1'b1;
         cause = CAUSE_M_EXT;
      end else if (irq_i[1]) begin
         intr  = 1'b1;
         cause = CAUSE_M_SW;
      end else if (irq_i[0]) begin
         intr  = 1'b1;
         cause = CAUSE_M_TIMER;
      end else if (mret_i) begin
         is_mret = 1'b1;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer
// Owns the CSR unit's single access port while it sequences trap entry
// (save mstatus/mepc/mcause, fetch mtvec) or MRET (restore mstatus, fetch
// mepc), then issues a one-cycle PC redirect. In IDLE the pipeline's CSR
// requests pass straight through.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   csr_bus                      : pipeline request in, CSR unit request out
//   except_valid_i/cause_i/pc_i  : exception and faulting PC[31:1]
//   irq_i, mret_i                : gated interrupts, MRET request
//   pipe_idle_i                  : pipeline drained
//   stall_o, flush_o, busy_o     : pipeline control while sequencing
//   redirect_o, redirect_pc_o    : one-cycle redirect and its target
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   trap_sequencer_if.master        csr_bus,
   input  logic                    except_valid_i,
   input  logic [3:0]              except_cause_i,
   input  logic [30:0]             except_pc_i,
   input  logic [2:0]              irq_i,
   input  logic                    mret_i,
   input  logic                    pipe_idle_i,
   output logic                    stall_o,
   output logic                    flush_o,
   output logic                    busy_o,
   output logic                    redirect_o,
   output logic [31:0]             redirect_pc_o
);

   seq_state_e  state;
   logic        is_mret;
   logic        intr_q;
   logic [3:0]  cause_q;
   logic [30:0] pc_q;
   logic [31:0] mstatus_q;
   logic [31:0] mstatus_wr;

   logic        ev_valid;
   logic        ev_intr;
   logic [3:0]  ev_cause;
   logic        ev_is_mret;

   trap_sequencer_prio_enc u_prio_enc (
      .except_valid_i (except_valid_i),
      .except_cause_i (except_cause_i),
      .irq_i          (irq_i),
      .mret_i         (mret_i),
      .valid          (ev_valid),
      .intr           (ev_intr),
      .cause          (ev_cause),
      .is_mret        (ev_is_mret)
   );

   // Sequencer FSM. Pipeline control outputs are registered and set on the
   // transition into the state they belong to, so they line up with state.
   // Reads latch csr_rdata_i at the end of their cycle; the mtvec/mepc reads
   // go straight into redirect_pc_o since that is their only consumer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         is_mret       <= 1'b0;
         intr_q        <= 1'b0;
         cause_q       <= 4'd0;
         pc_q          <= 31'd0;
         mstatus_q     <= 32'd0;
         stall_o       <= 1'b0;
         flush_o       <= 1'b0;
         busy_o        <= 1'b0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= RESET_PC;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ev_valid) begin
                  state   <= ST_DRAIN;
                  is_mret <= ev_is_mret;
                  intr_q  <= ev_intr;
                  cause_q <= ev_cause;
                  pc_q    <= except_pc_i;
                  stall_o <= 1'b1;
                  busy_o  <= 1'b1;
                  flush_o <= 1'b1;
               end
            end
            ST_DRAIN: begin
               flush_o <= 1'b0;
               if (pipe_idle_i)
                  state <= ST_RD_MST;
            end
            ST_RD_MST: begin
               mstatus_q <= csr_bus.csr_rdata_i;
               state     <= ST_WR_MST;
            end
            ST_WR_MST: begin
               state <= is_mret ? ST_RD_EPC : ST_WR_EPC;
            end
            ST_WR_EPC: begin
               state <= ST_WR_CAUSE;
            end
            ST_WR_CAUSE: begin
               state <= ST_RD_TVEC;
            end
            ST_RD_TVEC: begin
               state         <= ST_REDIR;
               redirect_o    <= 1'b1;
               redirect_pc_o <= trap_target(csr_bus.csr_rdata_i, intr_q, cause_q);
            end
            ST_RD_EPC: begin
               state         <= ST_REDIR;
               redirect_o    <= 1'b1;
               redirect_pc_o <= {csr_bus.csr_rdata_i[31:1], 1'b0};
            end
            ST_REDIR: begin
               state      <= ST_IDLE;
               redirect_o <= 1'b0;
               stall_o    <= 1'b0;
               busy_o     <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // New mstatus value: trap entry stacks MIE into MPIE and disables
   // interrupts; MRET restores MIE from MPIE and sets MPIE.
   always_comb begin
      mstatus_wr = mstatus_q;
      if (is_mret) begin
         mstatus_wr[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
         mstatus_wr[MSTATUS_MPIE] = 1'b1;
      end else begin
         mstatus_wr[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
         mstatus_wr[MSTATUS_MIE]  = 1'b0;
      end
   end

   // CSR port mux. DRAIN and REDIR issue a side-effect-free read of address
   // 0 so a stalled pipeline request is never forwarded.
   always_comb begin
      csr_bus.csr_addr_o = 12'h000;
      csr_bus.csr_data_o = 32'd0;
      csr_bus.csr_op_o   = CSR_OP_READ;
      csr_bus.csr_we_o   = 1'b0;
      case (state)
         ST_IDLE: begin
            csr_bus.csr_addr_o = csr_bus.pipe_csr_addr_i;
            csr_bus.csr_data_o = csr_bus.pipe_csr_data_i;
            csr_bus.csr_op_o   = csr_bus.pipe_csr_op_i;
            csr_bus.csr_we_o   = csr_bus.pipe_csr_we_i;
         end
         ST_RD_MST: begin
            csr_bus.csr_addr_o = CSR_MSTATUS;
         end
         ST_WR_MST: begin
            csr_bus.csr_addr_o = CSR_MSTATUS;
            csr_bus.csr_data_o = mstatus_wr;
            csr_bus.csr_op_o   = CSR_OP_WRITE;
            csr_bus.csr_we_o   = 1'b1;
         end
         ST_WR_EPC: begin
            csr_bus.csr_addr_o = CSR_MEPC;
            csr_bus.csr_data_o = {pc_q, 1'b0};
            csr_bus.csr_op_o   = CSR_OP_WRITE;
            csr_bus.csr_we_o   = 1'b1;
         end
         ST_WR_CAUSE: begin
            csr_bus.csr_addr_o = CSR_MCAUSE;
            csr_bus.csr_data_o = {intr_q, 27'd0, cause_q};
            csr_bus.csr_op_o   = CSR_OP_WRITE;
            csr_bus.csr_we_o   = 1'b1;
         end
         ST_RD_TVEC: begin
            csr_bus.csr_addr_o = CSR_MTVEC;
         end
         ST_RD_EPC: begin
            csr_bus.csr_addr_o = CSR_MEPC;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer
// Directed bench for trap_sequencer. A small CSR unit model holds
// mstatus/mtvec/mepc/mcause, returns combinational read data and logs every
// write so the order and values of the sequencer's CSR accesses can be
// compared against hand-computed expectations.
module tb_trap_sequencer;

   localparam logic [31:0] RESET_PC = 32'hDEAD_BEE0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        except_valid = 1'b0;
   logic [3:0]  except_cause = 4'd0;
   logic [30:0] except_pc = 31'd0;
   logic [2:0]  irq = 3'd0;
   logic        mret = 1'b0;
   logic        pipe_idle = 1'b1;
   logic        stall, flush, busy, redirect;
   logic [31:0] redirect_pc;

   int vec_count = 0;
   int err_count = 0;

   logic [31:0] m_mstatus = 32'd0;
   logic [31:0] m_mtvec   = 32'd0;
   logic [31:0] m_mepc    = 32'd0;
   logic [31:0] m_mcause  = 32'd0;
   logic [11:0] log_addr [64];
   logic [31:0] log_data [64];
   int          log_count = 0;

   trap_sequencer_if bus ();

   trap_sequencer #(.RESET_PC(RESET_PC)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .csr_bus        (bus),
      .except_valid_i (except_valid),
      .except_cause_i (except_cause),
      .except_pc_i    (except_pc),
      .irq_i          (irq),
      .mret_i         (mret),
      .pipe_idle_i    (pipe_idle),
      .stall_o        (stall),
      .flush_o        (flush),
      .busy_o         (busy),
      .redirect_o     (redirect),
      .redirect_pc_o  (redirect_pc)
   );

   always #5 clk = ~clk;

   // CSR unit model: combinational read for the presented address.
   always_comb begin
      case (bus.csr_addr_o)
         12'h300: bus.csr_rdata_i = m_mstatus;
         12'h305: bus.csr_rdata_i = m_mtvec;
         12'h341: bus.csr_rdata_i = m_mepc;
         12'h342: bus.csr_rdata_i = m_mcause;
         default: bus.csr_rdata_i = 32'd0;
      endcase
   end

   // CSR unit model: write on the clock edge and record each write.
   always @(posedge clk) begin
      if (bus.csr_we_o) begin
         case (bus.csr_addr_o)
            12'h300: m_mstatus <= bus.csr_data_o;
            12'h305: m_mtvec   <= bus.csr_data_o;
            12'h341: m_mepc    <= bus.csr_data_o;
            12'h342: m_mcause  <= bus.csr_data_o;
            default: begin end
         endcase
         log_addr[log_count[5:0]] <= bus.csr_addr_o;
         log_data[log_count[5:0]] <= bus.csr_data_o;
         log_count <= log_count + 1;
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_count++;
      if (obs !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ev, input logic [3:0] cause, input logic [30:0] pc,
                                input logic [2:0] irq_v, input logic mret_v);
      except_valid = ev;
      except_cause = cause;
      except_pc    = pc;
      irq          = irq_v;
      mret         = mret_v;
   endtask

   task automatic setPipe(input logic [11:0] addr, input logic [31:0] data,
                          input logic [1:0] op, input logic we);
      bus.pipe_csr_addr_i = addr;
      bus.pipe_csr_data_i = data;
      bus.pipe_csr_op_i   = op;
      bus.pipe_csr_we_i   = we;
   endtask

   task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
      setPipe(addr, data, 2'b01, 1'b1);
      stepCycle();
      setPipe(12'h000, 32'd0, 2'b00, 1'b0);
   endtask

   task automatic checkWrite(input string tag, input int idx, input logic [11:0] addr,
                             input logic [31:0] data);
      checkOutput({tag, "_addr"}, {20'd0, log_addr[idx[5:0]]}, {20'd0, addr});
      checkOutput({tag, "_data"}, log_data[idx[5:0]], data);
   endtask

   // Runs from the event cycle T until redirect_o, with pipe_idle held low
   // for drain_low cycles from T+1. With noise set, a pipeline CSR write and
   // an MRET pulse are presented while busy; both must be ignored.
   task automatic runSequence(input string tag, input int exp_lat, input logic [31:0] exp_pc,
                              input int drain_low, input bit noise);
      int lat;
      int flush_seen;
      bit flush_first;
      bit stall_gap;
      bit found;
      lat = 0; flush_seen = 0; flush_first = 1'b0; stall_gap = 1'b0; found = 1'b0;
      while (!found && lat < 60) begin
         stepCycle();
         lat++;
         pipe_idle = (lat > drain_low);
         if (lat == 1) begin
            applyStimulus(1'b0, 4'd0, 31'd0, 3'd0, 1'b0);
            setPipe(12'h000, 32'd0, 2'b00, 1'b0);
            flush_first = flush;
            if (noise) setPipe(12'h7C0, 32'h1234_5678, 2'b01, 1'b1);
         end
         if (noise && lat == 2) mret = 1'b1;
         if (noise && lat == 3) mret = 1'b0;
         if (flush) flush_seen++;
         if (!stall || !busy) stall_gap = 1'b1;
         if (redirect) found = 1'b1;
      end
      setPipe(12'h000, 32'd0, 2'b00, 1'b0);
      pipe_idle = 1'b1;
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_redirect_pc"}, redirect_pc, exp_pc);
      checkOutput({tag, "_flush_first"}, {31'd0, flush_first}, 32'd1);
      checkOutput({tag, "_flush_pulses"}, 32'(flush_seen), 32'd1);
      checkOutput({tag, "_stall_gap"}, {31'd0, stall_gap}, 32'd0);
      stepCycle();
      checkOutput({tag, "_redirect_drop"}, {31'd0, redirect}, 32'd0);
      checkOutput({tag, "_busy_drop"}, {30'd0, stall, busy}, 32'd0);
      checkOutput({tag, "_pc_hold"}, redirect_pc, exp_pc);
   endtask

   initial begin
      int base;
      int redirect_seen;
      setPipe(12'h000, 32'd0, 2'b00, 1'b0);
      stepCycle();
      stepCycle();
      rst = 1'b0;

      // Reset state and IDLE passthrough
      setPipe(12'h123, 32'hA5A5_0F0F, 2'b10, 1'b0);
      #1;
      checkOutput("rst_ctrl", {28'd0, stall, flush, busy, redirect}, 32'd0);
      checkOutput("rst_pc", redirect_pc, RESET_PC);
      checkOutput("pass_addr", {20'd0, bus.csr_addr_o}, 32'h0000_0123);
      checkOutput("pass_data", bus.csr_data_o, 32'hA5A5_0F0F);
      checkOutput("pass_opwe", {29'd0, bus.csr_op_o, bus.csr_we_o}, 32'h0000_0004);
      setPipe(12'h000, 32'd0, 2'b00, 1'b0);

      // Illegal instruction, with a same-cycle pipeline write of mtvec
      csrWrite(12'h300, 32'h0000_0008);
      base = log_count;
      setPipe(12'h305, 32'h8000_0000, 2'b01, 1'b1);
      applyStimulus(1'b1, 4'd2, 31'h0000_0080, 3'd0, 1'b0);
      runSequence("illegal", 7, 32'h8000_0000, 0, 1'b0);
      checkOutput("illegal_nwrites", 32'(log_count - base), 32'd4);
      checkWrite("illegal_w0", base,     12'h305, 32'h8000_0000);
      checkWrite("illegal_w1", base + 1, 12'h300, 32'h0000_0080);
      checkWrite("illegal_w2", base + 2, 12'h341, 32'h0000_0100);
      checkWrite("illegal_w3", base + 3, 12'h342, 32'h0000_0002);

      // Vectored external interrupt
      csrWrite(12'h300, 32'h0000_0008);
      csrWrite(12'h305, 32'h8000_0001);
      base = log_count;
      applyStimulus(1'b0, 4'd0, 31'h0000_0200, 3'b100, 1'b0);
      runSequence("ext_irq", 7, 32'h8000_002C, 0, 1'b0);
      checkOutput("ext_irq_nwrites", 32'(log_count - base), 32'd3);
      checkWrite("ext_irq_w0", base,     12'h300, 32'h0000_0080);
      checkWrite("ext_irq_w1", base + 1, 12'h341, 32'h0000_0400);
      checkWrite("ext_irq_w2", base + 2, 12'h342, 32'h8000_000B);

      // Exception + timer + MRET together: exception wins, vectored mode
      // still lands on the base, other mstatus bits are preserved
      csrWrite(12'h300, 32'h0000_1888);
      base = log_count;
      applyStimulus(1'b1, 4'd5, 31'h0000_0150, 3'b001, 1'b1);
      runSequence("simul", 7, 32'h8000_0000, 0, 1'b0);
      checkOutput("simul_nwrites", 32'(log_count - base), 32'd3);
      checkWrite("simul_w0", base,     12'h300, 32'h0000_1880);
      checkWrite("simul_w1", base + 1, 12'h341, 32'h0000_02A0);
      checkWrite("simul_w2", base + 2, 12'h342, 32'h0000_0005);

      // MRET
      csrWrite(12'h300, 32'h0000_0080);
      csrWrite(12'h341, 32'h0000_0204);
      base = log_count;
      applyStimulus(1'b0, 4'd0, 31'd0, 3'd0, 1'b1);
      runSequence("mret", 5, 32'h0000_0204, 0, 1'b0);
      checkOutput("mret_nwrites", 32'(log_count - base), 32'd1);
      checkWrite("mret_w0", base, 12'h300, 32'h0000_0088);

      // Drain hold for 5 cycles, with ignored pipeline write and MRET
      csrWrite(12'h300, 32'h0000_0008);
      csrWrite(12'h305, 32'h4000_0000);
      base = log_count;
      applyStimulus(1'b1, 4'd2, 31'h0000_0040, 3'd0, 1'b0);
      runSequence("drain", 12, 32'h4000_0000, 5, 1'b1);
      checkOutput("drain_nwrites", 32'(log_count - base), 32'd3);
      checkWrite("drain_w0", base,     12'h300, 32'h0000_0080);
      checkWrite("drain_w2", base + 2, 12'h342, 32'h0000_0002);

      // Reset while in WR_EPC
      csrWrite(12'h300, 32'h0000_0008);
      base = log_count;
      applyStimulus(1'b1, 4'd4, 31'h0000_0300, 3'd0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 4'd0, 31'd0, 3'd0, 1'b0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("rstmid_in_epc", {19'd0, bus.csr_we_o, bus.csr_addr_o}, 32'h0000_1341);
      rst = 1'b1;
      stepCycle();
      checkOutput("rstmid_ctrl", {28'd0, stall, flush, busy, redirect}, 32'd0);
      checkOutput("rstmid_pc", redirect_pc, RESET_PC);
      rst = 1'b0;
      setPipe(12'h456, 32'h0000_0077, 2'b11, 1'b0);
      #1;
      checkOutput("rstmid_pass_addr", {20'd0, bus.csr_addr_o}, 32'h0000_0456);
      checkOutput("rstmid_pass_op", {30'd0, bus.csr_op_o}, 32'h0000_0003);
      redirect_seen = 0;
      for (int i = 0; i < 8; i++) begin
         stepCycle();
         if (redirect || busy) redirect_seen++;
      end
      setPipe(12'h000, 32'd0, 2'b00, 1'b0);
      checkOutput("rstmid_no_redirect", 32'(redirect_seen), 32'd0);
      checkOutput("rstmid_nwrites", 32'(log_count - base), 32'd2);
      checkWrite("rstmid_w1", base + 1, 12'h341, 32'h0000_0600);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences trap entry and MRET by taking ownership of the CSR unit's single access port (addr/data/op/we) and issuing a fixed series of CSR reads and writes. Sits between the pipeline's CSR port and the CSR unit. Passes pipeline CSR accesses through when idle. Stalls and flushes the pipeline during a sequence, then issues a one-cycle PC redirect. Requires `mstatus` bit 7 (MPIE) to be implemented in the CSR unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `redirect_pc_o` out of reset.

Ports:
- `clk_i` in 1: clock. Single clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous, active-high reset.
- `pipe_csr_addr_i` in 12, `pipe_csr_data_i` in 32, `pipe_csr_op_i` in 2, `pipe_csr_we_i` in 1: pipeline CSR request.
- `csr_addr_o` out 12, `csr_data_o` out 32, `csr_op_o` out 2, `csr_we_o` out 1: to CSR unit.
- `csr_rdata_i` in 32: combinational read data from CSR unit for the current `csr_addr_o`.
- `except_valid_i` in 1: exception present.
- `except_cause_i` in 4: exception cause code.
- `except_pc_i` in 31: PC[31:1] of the faulting or interrupted instruction.
- `irq_i` in 3: {external, software, timer}, already gated by `mstatus.MIE`/`mie`.
- `mret_i` in 1: MRET in execute.
- `pipe_idle_i` in 1: pipeline drained, no outstanding memory access.
- `stall_o` out 1, `flush_o` out 1, `busy_o` out 1.
- `redirect_o` out 1, `redirect_pc_o` out 32.

## Operation
- **States:** IDLE, DRAIN, RD_MST, WR_MST, WR_EPC, WR_CAUSE, RD_TVEC, RD_EPC, REDIR. A `is_mret` flag selects the path.
- **IDLE:** `csr_*_o` = `pipe_csr_*_i`. Events are sampled each cycle.
- **Event priority:** `except_valid_i` > `irq_i[2]` (cause 11) > `irq_i[1]` (cause 3) > `irq_i[0]` (cause 7) > `mret_i`.
  - The winner's cause, interrupt bit, and PC are latched, then the FSM enters DRAIN.
- **DRAIN:** wait for `pipe_idle_i`, then go to RD_MST.
- **Trap path:**
  - RD_MST: read 0x300 and latch it.
  - WR_MST: CSRRW 0x300 with MPIE = old MIE, MIE = 0, other bits unchanged.
  - WR_EPC: CSRRW 0x341 with {pc, 1'b0}.
  - WR_CAUSE: CSRRW 0x342 with {intr, 27'd0, cause}.
  - RD_TVEC: read 0x305 and latch it.
  - REDIR.
- **MRET path:**
  - RD_MST: read 0x300 and latch it.
  - WR_MST: MIE = old MPIE, MPIE = 1.
  - RD_EPC: read 0x341 and latch it.
  - REDIR.
- **Reads** drive `op` = 2'b00, `we` = 0. **Writes** drive `op` = 2'b01, `we` = 1.
- **Target address:**
  - mtvec mode 00 → {base, 2'b00}.
  - mode 01 and interrupt → {base, 2'b00} + (cause << 2), 32-bit wrap.
  - mode 01 and exception → base.
  - modes 1x are reserved and treated as direct.
  - MRET target = {mepc[31:1], 1'b0}.
- **REDIR:** `redirect_o` = 1 and `redirect_pc_o` = target; return to IDLE next cycle.

## Timing
- **Reset values:** state IDLE; `stall_o`, `flush_o`, `busy_o`, `redirect_o` = 0; `redirect_pc_o` = `RESET_PC`; `csr_*_o` pass through.
- **Event sampled at cycle T:**
  - T+1: DRAIN.
  - `flush_o` = 1 only in the first DRAIN cycle.
  - `stall_o` = `busy_o` = 1 in every non-IDLE state.
- **Minimum latency (with `pipe_idle_i` high at T+1):**
  - Trap: `redirect_o` at T+7.
  - MRET: `redirect_o` at T+5.
- **Drain wait:** DRAIN holds indefinitely while `pipe_idle_i` = 0; `flush_o` is not re-pulsed.
- **`redirect_pc_o`** holds its last value after REDIR.
- **Events outside IDLE** are ignored. Level interrupts are re-sampled in IDLE.
  - An interrupt still asserted in the cycle after REDIR is not taken if `mstatus.MIE` was cleared, because the gating lives upstream.
- **Pipeline CSR request in a non-IDLE state:** ignored; the pipeline is stalled and holds it.
- **Same-cycle conflict:** a pipeline CSR write and an event in the same IDLE cycle → the write completes that cycle; the sequence starts at T+1.
- **Reset mid-sequence:** immediately back to IDLE. CSR writes already issued are not undone, and no redirect is issued.

## Structure
- New shared header `Trap_defs.vh`: state encodings and interrupt cause codes (11, 3, 7).
- CSR addresses come from `CSR_defs.vh`.
- Sub-module `trap_prio_enc`: combinational priority encoder, inputs `except_valid_i`/`irq_i`/`mret_i`, outputs {valid, intr, cause, is_mret}.
- Remainder: FSM, latches, and the CSR output mux in `trap_sequencer`.

## Test plan
- **Illegal instruction:** `except_valid_i` with cause 2, pc 0x100, mtvec 0x8000_0000 mode 00, MIE = 1 → writes in order 0x300 = 0x80, 0x341 = 0x100, 0x342 = 0x2; `redirect_o` at T+7 with pc 0x8000_0000.
- **Vectored external interrupt:** mtvec 0x8000_0001, `irq_i` = 3'b100 → mcause 0x8000_000B, redirect 0x8000_002C.
- **Simultaneous events:** exception plus timer plus `mret_i` in one cycle → exception path taken, mcause = exception cause, interrupt bit 0.
- **MRET:** mstatus = 0x80, mepc = 0x204 → write 0x300 = 0x88; `redirect_o` at T+5 with pc 0x204.
- **Drain hold:** `pipe_idle_i` held low for 5 cycles → `flush_o` pulses once, `stall_o` stays high, `redirect_o` is delayed by exactly 5.
- **Reset in WR_EPC:** `rst_i` asserted → next cycle all outputs at reset values, passthrough restored, no `redirect_o`.
